// File: rtl/tracker_pkg.sv
// Shared tracker defaults and arbiter state encoding.
// Pure declarations: no latency, no flow control.
package tracker_pkg;

    localparam int NB_SENSORS_DFLT = 4;
    localparam int DATA_W_DFLT     = 17;
    localparam int TS_W_DFLT       = 24;
    localparam int DUP_W           = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-set search starting at rr, with wrap-around.
// Latency 0 (pure logic); no flow control, the caller decides when to use the grant.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] rr,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    int              w_j;
    logic [ID_W-1:0] w_idx;

    // Scan from the farthest slot down so the slot closest to rr wins last.
    always_comb begin
        w_j       = 0;
        w_idx     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(rr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_idx = ID_W'(w_j);
            if (req[w_idx]) begin
                grant_idx = w_idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmc_capture_arbiter.sv
// Round-robin capture of pending BMC decoder words into one tagged holding register.
// Latency: out_valid 2 cycles after eligibility; backpressure: word held stable until out_ready.
module bmc_capture_arbiter
    import tracker_pkg::*;
#(
    parameter int NB_SENSORS = NB_SENSORS_DFLT,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int TS_W       = TS_W_DFLT
) (
    input  logic                           clk_96MHz,
    input  logic                           reset,
    input  logic [NB_SENSORS-1:0]          sensor_mask,
    output logic [NB_SENSORS-1:0]          dec_enable,
    input  logic [NB_SENSORS-1:0]          dec_avail,
    input  logic [NB_SENSORS*DATA_W-1:0]   dec_data,
    input  logic [NB_SENSORS*TS_W-1:0]     dec_ts,
    output logic [NB_SENSORS-1:0]          dec_clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NB_SENSORS)-1:0]  out_id,
    output logic [DATA_W-1:0]              out_data,
    output logic [TS_W-1:0]                out_ts,
    output logic [DUP_W-1:0]               dup_cnt
);

    localparam int ID_W = $clog2(NB_SENSORS);

    arb_state_e             r_state;
    arb_state_e             w_next_state;
    logic [ID_W-1:0]        r_rr;
    logic [ID_W-1:0]        r_idx;
    logic [NB_SENSORS-1:0]  r_seen;
    logic [TS_W-1:0]        r_last_ts [NB_SENSORS];
    logic [NB_SENSORS-1:0]  r_dec_enable;
    logic [NB_SENSORS-1:0]  r_dec_clear;
    logic                   r_out_valid;
    logic [ID_W-1:0]        r_out_id;
    logic [DATA_W-1:0]      r_out_data;
    logic [TS_W-1:0]        r_out_ts;
    logic [DUP_W-1:0]       r_dup_cnt;

    logic [DATA_W-1:0]      w_data [NB_SENSORS];
    logic [TS_W-1:0]        w_ts   [NB_SENSORS];
    logic [NB_SENSORS-1:0]  w_stale;
    logic [NB_SENSORS-1:0]  w_raw;
    logic [NB_SENSORS-1:0]  w_elig;
    logic [NB_SENSORS-1:0]  w_fall;
    logic [NB_SENSORS-1:0]  w_idx_oh;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_any;
    logic [ID_W-1:0]        w_raw_idx;
    logic                   w_raw_any;
    logic                   w_grant_ld;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_dup;

    for (genvar g = 0; g < NB_SENSORS; g++) begin : g_unpack
        assign w_data[g]  = dec_data[g*DATA_W +: DATA_W];
        assign w_ts[g]    = dec_ts[g*TS_W +: TS_W];
        // A word whose timestamp matches the last one taken from this sensor is a leftover.
        assign w_stale[g] = r_seen[g] & (w_ts[g] == r_last_ts[g]);
    end

    assign w_raw    = dec_avail & r_dec_enable;
    assign w_elig   = w_raw & ~w_stale;
    assign w_fall   = r_dec_enable & ~sensor_mask;
    assign w_idx_oh = NB_SENSORS'(1) << r_idx;

    rr_picker #(.N(NB_SENSORS), .ID_W(ID_W)) u_pick_elig (
        .req       (w_elig),
        .rr        (r_rr),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Same search ignoring the stale guard: tells which sensor a duplicate displaced.
    rr_picker #(.N(NB_SENSORS), .ID_W(ID_W)) u_pick_raw (
        .req       (w_raw),
        .rr        (r_rr),
        .grant_idx (w_raw_idx),
        .any       (w_raw_any)
    );

    assign w_dup = (r_state == IDLE) & w_raw_any & ~w_elig[w_raw_idx];

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_ld   = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_ld   = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = PRESENT;
            end
            PRESENT: begin
                if (r_out_valid & out_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_rr         <= '0;
            r_idx        <= '0;
            r_seen       <= '0;
            r_dec_enable <= '0;
            r_dec_clear  <= '0;
            r_out_valid  <= 1'b0;
            r_out_id     <= '0;
            r_out_data   <= '0;
            r_out_ts     <= '0;
            r_dup_cnt    <= '0;
            for (int i = 0; i < NB_SENSORS; i++) begin
                r_last_ts[i] <= '0;
            end
        end else begin
            r_dec_enable <= sensor_mask;
            r_dec_clear  <= w_capture ? w_idx_oh : '0;
            // Unmasking later must be able to re-offer a word with a repeated timestamp.
            r_seen       <= (r_seen | (w_capture ? w_idx_oh : '0)) & ~w_fall;
            if (w_grant_ld) begin
                r_idx <= w_grant_idx;
            end
            if (w_capture) begin
                r_out_data       <= w_data[r_idx];
                r_out_ts         <= w_ts[r_idx];
                r_out_id         <= r_idx;
                r_last_ts[r_idx] <= w_ts[r_idx];
                r_out_valid      <= 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_rr        <= (r_idx == ID_W'(NB_SENSORS - 1)) ? '0 : r_idx + 1'b1;
            end
            if (w_dup && (r_dup_cnt != {DUP_W{1'b1}})) begin
                r_dup_cnt <= r_dup_cnt + 1'b1;
            end
        end
    end

    assign dec_enable = r_dec_enable;
    assign dec_clear  = r_dec_clear;
    assign out_valid  = r_out_valid;
    assign out_id     = r_out_id;
    assign out_data   = r_out_data;
    assign out_ts     = r_out_ts;
    assign dup_cnt    = r_dup_cnt;

endmodule
